// File: rtl/amp_pwr_seq.sv
// Class-D output power sequencer: power-up hold, fault filter/retry/lockout, and a 0..unity gain ramp on the sample path.
// Latency: scaled samples appear exactly 1 cycle after vld; sht_dwn rises 1 cycle after a qualified fault is seen.
// Backpressure: none, the sample path is a pure strobe pipeline and accepts a pair on every vld.
module amp_pwr_seq #(
   parameter int PWRUP_CYC = 250000,   // clk cycles sht_dwn is held high before enabling
   parameter int FLT_FILT  = 4,        // consecutive low synced Flt_n cycles that qualify a fault
   parameter int MAX_RETRY = 3         // fault count that latches the lockout
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vld,
   input  logic signed [15:0] lft_in,
   input  logic signed [15:0] rght_in,
   input  logic               Flt_n,
   output logic               sht_dwn,
   output logic               vld_out,
   output logic signed [15:0] lft_out,
   output logic signed [15:0] rght_out,
   output logic               lockout,
   output logic [1:0]         flt_cnt
);

   // Timer must hold PWRUP_CYC-1; keep at least one bit for degenerate settings.
   localparam int TMR_W  = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;
   localparam int FILT_W = $clog2(FLT_FILT + 1);

   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(PWRUP_CYC - 1);
   localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(FLT_FILT);
   localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);
   localparam logic [8:0]        GAIN_UNITY = 9'd256;

   typedef enum logic [2:0] {
      ST_SHTDN   = 3'd0,
      ST_RAMP_UP = 3'd1,
      ST_RUN     = 3'd2,
      ST_FAULT   = 3'd3,
      ST_LOCK    = 3'd4
   } state_t;

   // Fault input conditioning
   logic              r_flt_s1;
   logic              r_flt_s2;
   logic [FILT_W-1:0] r_filt_cnt;
   logic              w_flt;

   // Sequencer state
   state_t            r_state;
   logic [TMR_W-1:0]  r_timer;
   logic [8:0]        r_gain;
   logic [1:0]        r_flt_cnt;
   logic              r_sht_dwn;
   logic              r_lockout;
   logic [1:0]        w_flt_cnt_inc;
   logic              w_to_lock;

   // Sample path
   logic              r_vld_out;
   logic signed [15:0] r_lft_out;
   logic signed [15:0] r_rght_out;
   logic signed [25:0] w_gain_s;
   logic signed [25:0] w_lft_s;
   logic signed [25:0] w_rght_s;
   logic signed [25:0] w_prod_l;
   logic signed [25:0] w_prod_r;
   logic signed [15:0] w_lft_scl;
   logic signed [15:0] w_rght_scl;

   //--------------------------------------------------------------------
   // Fault input path
   //--------------------------------------------------------------------

   // Two-flop synchronizer for the asynchronous fault line, preset to the idle-high level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flt_s1 <= 1'b1;
         r_flt_s2 <= 1'b1;
      end else begin
         r_flt_s1 <= Flt_n;
         r_flt_s2 <= r_flt_s1;
      end
   end

   // Count consecutive low synchronized samples; saturate so a long fault keeps flt asserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_filt_cnt <= '0;
      end else if (r_flt_s2) begin
         r_filt_cnt <= '0;
      end else if (r_filt_cnt != FILT_MAX) begin
         r_filt_cnt <= r_filt_cnt + FILT_W'(1);
      end
   end

   // Qualified fault: the line has been low for FLT_FILT synchronized cycles and still is.
   assign w_flt = (r_filt_cnt == FILT_MAX);

   //--------------------------------------------------------------------
   // Sequencer
   //--------------------------------------------------------------------

   // Fault count after this fault, saturating; reaching the retry limit diverts to LOCK.
   assign w_flt_cnt_inc = (r_flt_cnt == RETRY_MAX) ? r_flt_cnt : (r_flt_cnt + 2'd1);
   assign w_to_lock     = (w_flt_cnt_inc == RETRY_MAX);

   // Power/gain state machine with registered shutdown, lockout and fault count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_SHTDN;
         r_timer   <= '0;
         r_gain    <= '0;
         r_flt_cnt <= '0;
         r_sht_dwn <= 1'b1;
         r_lockout <= 1'b0;
      end else begin
         case (r_state)
            // SHTDN and FAULT share the hold-off: timer runs only through fault-free cycles.
            ST_SHTDN, ST_FAULT: begin
               r_sht_dwn <= 1'b1;
               r_gain    <= '0;
               if (w_flt) begin
                  r_timer <= '0;
               end else if (r_timer == TMR_LAST) begin
                  r_timer   <= '0;
                  r_state   <= ST_RAMP_UP;
                  r_sht_dwn <= 1'b0;
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end

            // Amp enabled; gain climbs one step per sample until unity.
            ST_RAMP_UP: begin
               if (w_flt) begin
                  r_flt_cnt <= w_flt_cnt_inc;
                  r_gain    <= '0;
                  r_timer   <= '0;
                  r_sht_dwn <= 1'b1;
                  r_lockout <= w_to_lock;
                  r_state   <= w_to_lock ? ST_LOCK : ST_FAULT;
               end else if (vld) begin
                  r_gain <= r_gain + 9'd1;
                  if (r_gain == (GAIN_UNITY - 9'd1)) begin
                     r_state <= ST_RUN;
                  end
               end
            end

            // Full-gain operation; only a qualified fault leaves this state.
            ST_RUN: begin
               r_gain <= GAIN_UNITY;
               if (w_flt) begin
                  r_flt_cnt <= w_flt_cnt_inc;
                  r_gain    <= '0;
                  r_timer   <= '0;
                  r_sht_dwn <= 1'b1;
                  r_lockout <= w_to_lock;
                  r_state   <= w_to_lock ? ST_LOCK : ST_FAULT;
               end
            end

            // Terminal after repeated faults; only reset recovers.
            ST_LOCK: begin
               r_sht_dwn <= 1'b1;
               r_gain    <= '0;
               r_lockout <= 1'b1;
            end

            default: begin
               r_state   <= ST_SHTDN;
               r_timer   <= '0;
               r_gain    <= '0;
               r_sht_dwn <= 1'b1;
            end
         endcase
      end
   end

   //--------------------------------------------------------------------
   // Sample path
   //--------------------------------------------------------------------

   // Extend operands explicitly so the multiply is a clean signed 26x26 in range.
   assign w_gain_s = {17'd0, r_gain};
   assign w_lft_s  = {{10{lft_in[15]}}, lft_in};
   assign w_rght_s = {{10{rght_in[15]}}, rght_in};
   assign w_prod_l = w_lft_s * w_gain_s;
   assign w_prod_r = w_rght_s * w_gain_s;

   // Arithmetic shift floors; gain <= 256 guarantees the result fits 16 bits.
   assign w_lft_scl  = 16'(w_prod_l >>> 8);
   assign w_rght_scl = 16'(w_prod_r >>> 8);

   // Register scaled samples using the gain in force before this cycle's update; hold between strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_out  <= 1'b0;
         r_lft_out  <= '0;
         r_rght_out <= '0;
      end else begin
         r_vld_out <= vld;
         if (vld) begin
            r_lft_out  <= w_lft_scl;
            r_rght_out <= w_rght_scl;
         end
      end
   end

   assign sht_dwn  = r_sht_dwn;
   assign lockout  = r_lockout;
   assign flt_cnt  = r_flt_cnt;
   assign vld_out  = r_vld_out;
   assign lft_out  = r_lft_out;
   assign rght_out = r_rght_out;

endmodule

// File: tb/tb_amp_pwr_seq.sv
// Bench for amp_pwr_seq: randomized samples and fault-line activity against a behavioural model.
// Model view: the amp is either off (waiting for PWRUP quiet cycles) or on (gain ramping to unity).
// Every cycle all outputs are compared; directed phases follow the power-up/ramp/fault/lockout story.
module tb_amp_pwr_seq;

   localparam int PWRUP = 100;
   localparam int FILT  = 4;
   localparam int RETRY = 3;
   localparam int HLEN  = FILT + 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vld = 1'b0;
   logic signed [15:0] lft_in = '0;
   logic signed [15:0] rght_in = '0;
   logic Flt_n = 1'b1;
   logic sht_dwn;
   logic vld_out;
   logic signed [15:0] lft_out;
   logic signed [15:0] rght_out;
   logic lockout;
   logic [1:0] flt_cnt;

   amp_pwr_seq #(
      .PWRUP_CYC (PWRUP),
      .FLT_FILT  (FILT),
      .MAX_RETRY (RETRY)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .vld      (vld),
      .lft_in   (lft_in),
      .rght_in  (rght_in),
      .Flt_n    (Flt_n),
      .sht_dwn  (sht_dwn),
      .vld_out  (vld_out),
      .lft_out  (lft_out),
      .rght_out (rght_out),
      .lockout  (lockout),
      .flt_cnt  (flt_cnt)
   );

   always #10 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // Single comparison point for the whole bench.
   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_on, m_lock, m_vo;
   int m_gain, m_faults, m_quiet, m_lft, m_rght;
   bit fhist[$];

   // floor(s*g/256) with plain integer arithmetic
   function automatic int scale(input int s, input int g);
      int p, q;
      p = s * g;
      q = p / 256;
      if (p < 0 && (p % 256) != 0) q = q - 1;
      return q;
   endfunction

   task automatic model_reset();
      m_on = 0; m_lock = 0; m_vo = 0;
      m_gain = 0; m_faults = 0; m_quiet = 0; m_lft = 0; m_rght = 0;
      fhist.delete();
      repeat (HLEN) fhist.push_back(1'b1);
   endtask

   // One clock edge: inputs are those applied before the edge.
   task automatic model_edge();
      bit flt;
      if (rst) begin
         model_reset();
         return;
      end
      fhist.push_back(Flt_n);
      void'(fhist.pop_front());
      // Fault is seen when the line was low at every one of the FILT edges
      // 3..FILT+2 ago (two synchronizer stages plus the filter register).
      flt = 1'b1;
      for (int k = 3; k < 3 + FILT; k++) if (fhist[HLEN-1-k]) flt = 1'b0;

      m_vo = vld;
      if (vld) begin
         m_lft  = scale(int'(lft_in), m_gain);
         m_rght = scale(int'(rght_in), m_gain);
      end

      if (m_lock) begin
         // stays locked
      end else if (m_on) begin
         if (flt) begin
            m_on = 0; m_gain = 0; m_quiet = 0;
            if (m_faults < RETRY) m_faults++;
            if (m_faults == RETRY) m_lock = 1;
         end else if (vld && m_gain < 256) begin
            m_gain++;
         end
      end else begin
         m_gain = 0;
         if (flt) m_quiet = 0;
         else m_quiet++;
         if (m_quiet == PWRUP) begin
            m_on = 1;
            m_quiet = 0;
         end
      end
   endtask

   task automatic check_outputs();
      chk("sht_dwn",  sht_dwn,  !m_on);
      chk("lockout",  lockout,  m_lock);
      chk("flt_cnt",  flt_cnt,  m_faults);
      chk("vld_out",  vld_out,  m_vo);
      chk("lft_out",  lft_out,  m_lft);
      chk("rght_out", rght_out, m_rght);
   endtask

   // Advance one clock, update the model, compare #1 after the edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic rand_sample(input int one_in);
      vld     = ($urandom_range(0, one_in - 1) == 0);
      lft_in  = 16'($urandom);
      rght_in = 16'($urandom);
   endtask

   // Wait (bounded) for the amp to come on; returns cycles spent.
   task automatic wait_enable(input int budget, output int cyc);
      cyc = 0;
      while (sht_dwn && cyc < budget) begin
         rand_sample(3);
         step();
         cyc++;
      end
      vld = 1'b0;
   endtask

   int cyc, lat, low_left, hi_cnt;

   initial begin
      model_reset();
      step();
      step();
      // reset values
      chk("rst_sht_dwn", sht_dwn, 1);
      chk("rst_lockout", lockout, 0);
      chk("rst_flt_cnt", flt_cnt, 0);
      chk("rst_vld_out", vld_out, 0);
      chk("rst_lft", lft_out, 0);

      // ---- power-up: sht_dwn must fall exactly PWRUP cycles after release
      rst = 1'b0;
      wait_enable(PWRUP + 50, cyc);
      chk("pwrup_cycles", cyc, PWRUP);
      chk("pwrup_flt_cnt", flt_cnt, 0);

      // ---- ramp with 1000/-1000 every 8 cycles; a mid-ramp probe at gain 128
      for (int i = 0; i < 8 * 300 && m_gain < 256; i++) begin
         vld     = ((i % 8) == 0);
         lft_in  = (m_gain == 128) ? -16'sd1 : 16'sd1000;
         rght_in = (m_gain == 128) ? 16'sd1000 : -16'sd1000;
         step();
         if (vld && m_gain == 129) begin
            chk("g128_neg1", lft_out, -1);
            chk("g128_1000", rght_out, 500);
         end
      end
      chk("ramp_reached", m_gain, 256);
      vld = 1'b1; lft_in = 16'sd1000; rght_in = -16'sd1000;
      step();
      vld = 1'b0;
      chk("unity_l", lft_out, 1000);
      chk("unity_r", rght_out, -1000);
      chk("unity_vo", vld_out, 1);
      step();
      chk("vo_one_cycle", vld_out, 0);

      // ---- extremes at unity
      vld = 1'b1; lft_in = -16'sd32768; rght_in = 16'sd32767;
      step();
      vld = 1'b0;
      chk("min_pass", lft_out, -32768);
      chk("max_pass", rght_out, 32767);
      for (int i = 0; i < 200; i++) begin
         rand_sample(2);
         step();
      end

      // ---- glitches shorter than the filter are ignored
      for (int g = 0; g < 10; g++) begin
         Flt_n = 1'b0;
         repeat ($urandom_range(1, FILT - 1)) begin rand_sample(3); step(); end
         Flt_n = 1'b1;
         repeat (8) begin rand_sample(3); step(); end
      end
      chk("glitch_sht_dwn", sht_dwn, 0);
      chk("glitch_flt_cnt", flt_cnt, 0);

      // ---- qualified fault in RUN: 20 low cycles
      Flt_n = 1'b0; vld = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (sht_dwn && lat == 0) lat = i;
      end
      chk("fault_latency_ok", (lat >= 1 && lat <= 2 + FILT + 1), 1);
      chk("fault_flt_cnt", flt_cnt, 1);
      vld = 1'b1; lft_in = 16'sd1000; rght_in = -16'sd1000;
      step();
      vld = 1'b0;
      chk("fault_mute_l", lft_out, 0);
      chk("fault_mute_r", rght_out, 0);
      Flt_n = 1'b1;
      // two synchronizer stages + filter clear before the hold-off starts
      wait_enable(PWRUP + 50, cyc);
      chk("reenable_cycles", cyc, PWRUP + 3);
      vld = 1'b1; lft_in = 16'sd1000; rght_in = 16'sd1000;
      step();
      vld = 1'b0;
      chk("ramp_restart", lft_out, 0);
      for (int i = 0; i < 40; i++) begin
         rand_sample(2);
         step();
      end

      // ---- two more faults -> lockout
      for (int f = 2; f <= RETRY; f++) begin
         Flt_n = 1'b0;
         repeat (12) begin rand_sample(3); step(); end
         Flt_n = 1'b1;
         if (f < RETRY) begin
            wait_enable(PWRUP + 50, cyc);
            chk("retry_enable", sht_dwn, 0);
         end
      end
      chk("lock_lockout", lockout, 1);
      chk("lock_flt_cnt", flt_cnt, RETRY);
      hi_cnt = 0;
      for (int i = 0; i < 10000; i++) begin
         rand_sample(4);
         step();
         if (!sht_dwn) hi_cnt++;
      end
      chk("lock_held", hi_cnt, 0);
      chk("lock_mute", lft_out, 0);

      // ---- asynchronous reset mid-lock
      #5;
      rst = 1'b1;
      #1;
      model_reset();
      chk("arst_lockout", lockout, 0);
      chk("arst_flt_cnt", flt_cnt, 0);
      chk("arst_sht_dwn", sht_dwn, 1);
      chk("arst_vld_out", vld_out, 0);
      chk("arst_lft", lft_out, 0);
      chk("arst_rght", rght_out, 0);
      vld = 1'b0;
      step();
      step();
      rst = 1'b0;

      // ---- randomized soak: fault bursts of random length, periodic resets
      for (int r = 0; r < 5; r++) begin
         low_left = 0;
         for (int i = 0; i < 3000; i++) begin
            if (low_left > 0) begin
               Flt_n = 1'b0;
               low_left--;
            end else begin
               Flt_n = 1'b1;
               if ($urandom_range(0, 149) == 0) low_left = $urandom_range(1, 12);
            end
            rand_sample(3);
            step();
         end
         Flt_n = 1'b1; vld = 1'b0;
         rst = 1'b1;
         step();
         rst = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
